// File: rtl/bomb_ctrl_if.sv
// Bus between the bomb controller and whatever drives its inputs and reads its outputs.
// Inputs are one-cycle pulses, except key (data) and mute_btn (level).
interface bomb_ctrl_if;
  logic       tick;
  logic       arm;
  logic       key_valid;
  logic [3:0] key;
  logic       mute_btn;
  logic       bomb;
  logic       defused;
  logic       u10;
  logic       mute;
  logic [6:0] sec;
  logic [1:0] strikes;

  modport master (
    output tick, arm, key_valid, key, mute_btn,
    input  bomb, defused, u10, mute, sec, strikes
  );

  modport slave (
    input  tick, arm, key_valid, key, mute_btn,
    output bomb, defused, u10, mute, sec, strikes
  );
endinterface

// File: rtl/bomb_ctrl.sv
// Countdown bomb game controller: arm, count down, enter a 4-digit code or explode.
// Optional macro BOMB_CTRL_PENALTY_EN: each wrong code also removes 10 seconds.
module bomb_ctrl #(
  parameter int          START_SEC   = 60,
  parameter logic [15:0] CODE        = 16'h1234,
  parameter int          MAX_STRIKES = 3
) (
  input  logic        clk,
  input  logic        rst,
  bomb_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_BOOM    = 2'd2,
    S_DEFUSED = 2'd3
  } state_t;

  localparam logic [6:0] START_V = 7'(START_SEC);
  localparam logic [1:0] MAX_V   = 2'(MAX_STRIKES);

  state_t     state_r, state_nx_s;
  logic [6:0] sec_r, sec_nx_s;
  logic [1:0] strikes_r, strikes_nx_s;
  logic [1:0] idx_r, idx_nx_s;
  logic       mis_r, mis_nx_s;
  logic       dig_mis_s, wrong_s, right_s, boom_s;
  logic       btn_d_r, mute_r;
  logic       bomb_r, defused_r, u10_r;

  function automatic logic [3:0] code_digit(input logic [1:0] i);
    case (i)
      2'd0:    return CODE[15:12];
      2'd1:    return CODE[11:8];
      2'd2:    return CODE[7:4];
      2'd3:    return CODE[3:0];
      default: return 4'd0;
    endcase
  endfunction

  // Next-state computation; a correct final digit takes priority over a same-cycle tick.
  always_comb begin
    state_nx_s   = state_r;
    sec_nx_s     = sec_r;
    strikes_nx_s = strikes_r;
    idx_nx_s     = idx_r;
    mis_nx_s     = mis_r;
    dig_mis_s    = 1'b0;
    wrong_s      = 1'b0;
    right_s      = 1'b0;
    boom_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.arm) begin
          state_nx_s   = S_ARMED;
          sec_nx_s     = START_V;
          strikes_nx_s = 2'd0;
          idx_nx_s     = 2'd0;
          mis_nx_s     = 1'b0;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_ARMED: begin
        if (bus.key_valid) begin
          dig_mis_s = (bus.key != code_digit(idx_r));
          if (idx_r == 2'd3) begin
            if (mis_r || dig_mis_s) begin
              wrong_s = 1'b1;
            end else begin
              right_s = 1'b1;
            end
          end else begin
            idx_nx_s = idx_r + 2'd1;
            mis_nx_s = mis_r | dig_mis_s;
          end
        end else begin
          idx_nx_s = idx_r;
        end
        if (right_s) begin
          state_nx_s = S_DEFUSED;
        end else begin
          if (bus.tick) begin
            if (sec_r > 7'd1) begin
              sec_nx_s = sec_r - 7'd1;
            end else begin
              sec_nx_s = 7'd0;
              boom_s   = 1'b1;
            end
          end else begin
            sec_nx_s = sec_r;
          end
          if (wrong_s) begin
            strikes_nx_s = strikes_r + 2'd1;
            idx_nx_s     = 2'd0;
            mis_nx_s     = 1'b0;
            if (strikes_nx_s == MAX_V) begin
              boom_s = 1'b1;
            end else begin
              strikes_nx_s = strikes_r + 2'd1;
            end
`ifdef BOMB_CTRL_PENALTY_EN
            // Penalty saturates at zero, and zero means the bomb goes off.
            if (sec_nx_s > 7'd10) begin
              sec_nx_s = sec_nx_s - 7'd10;
            end else begin
              sec_nx_s = 7'd0;
              boom_s   = 1'b1;
            end
`endif
          end else begin
            strikes_nx_s = strikes_r;
          end
          if (boom_s) begin
            state_nx_s = S_BOOM;
          end else begin
            state_nx_s = S_ARMED;
          end
        end
      end
      S_BOOM, S_DEFUSED: begin
        if (bus.arm) begin
          state_nx_s = S_IDLE;
          sec_nx_s   = 7'd0;
        end else begin
          state_nx_s = state_r;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
        sec_nx_s   = 7'd0;
      end
    endcase
  end

  // Game state registers with status flags decoded from the next state so they stay registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= S_IDLE;
      sec_r     <= 7'd0;
      strikes_r <= 2'd0;
      idx_r     <= 2'd0;
      mis_r     <= 1'b0;
      bomb_r    <= 1'b0;
      defused_r <= 1'b0;
      u10_r     <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      sec_r     <= sec_nx_s;
      strikes_r <= strikes_nx_s;
      idx_r     <= idx_nx_s;
      mis_r     <= mis_nx_s;
      bomb_r    <= (state_nx_s == S_BOOM);
      defused_r <= (state_nx_s == S_DEFUSED);
      u10_r     <= (state_nx_s == S_ARMED) && (sec_nx_s < 7'd10);
    end
  end

  // Mute toggles once per rising edge of the button, whatever the game state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_d_r <= 1'b0;
      mute_r  <= 1'b0;
    end else begin
      btn_d_r <= bus.mute_btn;
      if (bus.mute_btn && !btn_d_r) begin
        mute_r <= !mute_r;
      end else begin
        mute_r <= mute_r;
      end
    end
  end

  assign bus.bomb    = bomb_r;
  assign bus.defused = defused_r;
  assign bus.u10     = u10_r;
  assign bus.mute    = mute_r;
  assign bus.sec     = sec_r;
  assign bus.strikes = strikes_r;

endmodule

// File: tb/tb_bomb_ctrl.sv
// Self-checking bench for bomb_ctrl: directed table, corner sequences, random run vs. a game model.
// Penalty sequence is exercised only when BOMB_CTRL_PENALTY_EN is defined.
module tb_bomb_ctrl;
  localparam int START = 12;
  localparam logic [15:0] CODE_V = 16'h1234;
  localparam int MAXS = 3;
  localparam int M_IDLE = 0, M_ARMED = 1, M_BOOM = 2, M_DEF = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bomb_ctrl_if bif ();

  bomb_ctrl #(.START_SEC(START), .CODE(CODE_V), .MAX_STRIKES(MAXS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // behavioural game model
  int mstate, msec, mstr, mmute, mprev;
  int mq[$];
  int cd[4];

  typedef struct {
    logic tick, arm, kv;
    logic [3:0] key;
    int eb, ed, es, est;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mstate = M_IDLE; msec = 0; mstr = 0; mmute = 0; mprev = 0;
    mq.delete();
  endtask

  task automatic model_step(input int t, input int a, input int kv, input int k, input int mb);
    int boom, right, wrong;
    boom = 0; right = 0; wrong = 0;
    if (mb != 0 && mprev == 0) mmute = 1 - mmute;
    mprev = mb;
    case (mstate)
      M_IDLE: if (a != 0) begin
        mstate = M_ARMED; msec = START; mstr = 0; mq.delete();
      end
      M_ARMED: begin
        if (kv != 0) begin
          mq.push_back(k);
          if (mq.size() == 4) begin
            right = 1;
            for (int i = 0; i < 4; i++) if (mq[i] != cd[i]) right = 0;
            wrong = 1 - right;
            mq.delete();
          end
        end
        if (right != 0) mstate = M_DEF;
        else begin
          if (t != 0) begin
            msec = msec - 1;
            if (msec <= 0) begin msec = 0; boom = 1; end
          end
          if (wrong != 0) begin
            mstr = mstr + 1;
            if (mstr == MAXS) boom = 1;
`ifdef BOMB_CTRL_PENALTY_EN
            msec = (msec >= 10) ? msec - 10 : 0;
            if (msec == 0) boom = 1;
`endif
          end
          if (boom != 0) mstate = M_BOOM;
        end
      end
      default: if (a != 0) begin mstate = M_IDLE; msec = 0; end
    endcase
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".bomb"},    32'(bif.bomb),    32'(mstate == M_BOOM));
    chk({tag, ".defused"}, 32'(bif.defused), 32'(mstate == M_DEF));
    chk({tag, ".u10"},     32'(bif.u10),     32'(mstate == M_ARMED && msec < 10));
    chk({tag, ".sec"},     32'(bif.sec),     32'(msec));
    chk({tag, ".strikes"}, 32'(bif.strikes), 32'(mstr));
    chk({tag, ".mute"},    32'(bif.mute),    32'(mmute));
  endtask

  task automatic cycle(input logic t, input logic a, input logic kv, input logic [3:0] k,
                       input logic mb, input string tag);
    @(negedge clk);
    bif.tick = t; bif.arm = a; bif.key_valid = kv; bif.key = k; bif.mute_btn = mb;
    model_step(int'(t), int'(a), int'(kv), int'(k), int'(mb));
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic go_idle();
    if (mstate != M_IDLE) cycle(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, "to_idle");
  endtask

  task automatic enter_code(input logic [3:0] d0, input logic [3:0] d1,
                            input logic [3:0] d2, input logic [3:0] d3);
    cycle(1'b0, 1'b0, 1'b1, d0, 1'b0, "code");
    cycle(1'b0, 1'b0, 1'b1, d1, 1'b0, "code");
    cycle(1'b0, 1'b0, 1'b1, d2, 1'b0, "code");
    cycle(1'b0, 1'b0, 1'b1, d3, 1'b0, "code");
  endtask

  function automatic vec_t mk(input logic t, input logic a, input logic kv, input logic [3:0] k,
                              input int eb, input int ed, input int es, input int est);
    vec_t v;
    v.tick = t; v.arm = a; v.kv = kv; v.key = k;
    v.eb = eb; v.ed = ed; v.es = es; v.est = est;
    return v;
  endfunction

  initial begin
    logic t, a, kv, mb;
    logic [3:0] k;
    for (int i = 0; i < 4; i++) cd[i] = (int'(CODE_V) >> (12 - 4 * i)) & 15;
    bif.tick = 1'b0; bif.arm = 1'b0; bif.key_valid = 1'b0; bif.key = 4'd0; bif.mute_btn = 1'b0;
    model_reset();

    // defuse, then three wrong codes
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 12, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 12, 0));
    tbl.push_back(mk(0, 0, 1, 2, 0, 0, 12, 0));
    tbl.push_back(mk(1, 0, 1, 3, 0, 0, 11, 0));
    tbl.push_back(mk(0, 0, 1, 4, 0, 1, 11, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 11, 0));
    tbl.push_back(mk(1, 0, 1, 4, 0, 1, 11, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 12, 0));
    for (int r = 1; r <= 3; r++) begin
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 12, r - 1));
      tbl.push_back(mk(0, 0, 1, 2, 0, 0, 12, r - 1));
      tbl.push_back(mk(0, 0, 1, 3, 0, 0, 12, r - 1));
`ifdef BOMB_CTRL_PENALTY_EN
      tbl.push_back(mk(0, 0, 1, 5, (r >= 2) ? 1 : 0, 0, (r >= 2) ? 0 : 2, r));
      if (r == 2) break;
`else
      tbl.push_back(mk(0, 0, 1, 5, (r == 3) ? 1 : 0, 0, 12, r));
`endif
    end
    tbl.push_back(mk(1, 0, 1, 1, 1, 0, -1, -1));

    repeat (3) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // mute: two 5-cycle presses
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 5; c++) cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, "mute_press");
      chk("mute_after_press", 32'(bif.mute), (p == 0) ? 32'd1 : 32'd0);
      for (int c = 0; c < 3; c++) cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, "mute_rel");
    end

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].tick, tbl[i].arm, tbl[i].kv, tbl[i].key, 1'b0, "tbl");
      chk("tbl.bomb", 32'(bif.bomb), 32'(tbl[i].eb));
      chk("tbl.defused", 32'(bif.defused), 32'(tbl[i].ed));
      if (tbl[i].es >= 0) chk("tbl.sec", 32'(bif.sec), 32'(tbl[i].es));
      if (tbl[i].est >= 0) chk("tbl.strikes", 32'(bif.strikes), 32'(tbl[i].est));
    end

    // full countdown to detonation
    go_idle();
    cycle(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, "cd_arm");
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, "cd_tick");
      if (i == 2) chk("cd_u10_early", 32'(bif.u10), 32'd0);
      if (i == 3) begin
        chk("cd_u10", 32'(bif.u10), 32'd1);
        chk("cd_sec9", 32'(bif.sec), 32'd9);
      end
      if (i == 11) chk("cd_no_boom", 32'(bif.bomb), 32'd0);
      if (i == 12) begin
        chk("cd_boom", 32'(bif.bomb), 32'd1);
        chk("cd_sec0", 32'(bif.sec), 32'd0);
      end
    end
    cycle(1'b1, 1'b0, 1'b1, 4'd1, 1'b0, "boom_ignores");

    // last-second defuse beats the tick
    go_idle();
    cycle(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, "ls_arm");
    repeat (11) cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, "ls_tick");
    cycle(1'b0, 1'b0, 1'b1, 4'd1, 1'b0, "ls_key");
    cycle(1'b0, 1'b0, 1'b1, 4'd2, 1'b0, "ls_key");
    cycle(1'b0, 1'b1, 1'b1, 4'd3, 1'b0, "ls_key_arm_ignored");
    cycle(1'b1, 1'b0, 1'b1, 4'd4, 1'b0, "ls_final");
    chk("ls_defused", 32'(bif.defused), 32'd1);
    chk("ls_sec1", 32'(bif.sec), 32'd1);
    chk("ls_bomb", 32'(bif.bomb), 32'd0);

    // last-second wrong code together with the tick
    go_idle();
    cycle(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, "lw_arm");
    repeat (11) cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, "lw_tick");
    cycle(1'b0, 1'b0, 1'b1, 4'd9, 1'b0, "lw_key");
    cycle(1'b0, 1'b0, 1'b1, 4'd2, 1'b0, "lw_key");
    cycle(1'b0, 1'b0, 1'b1, 4'd3, 1'b0, "lw_key");
    cycle(1'b1, 1'b0, 1'b1, 4'd4, 1'b0, "lw_final");
    chk("lw_bomb", 32'(bif.bomb), 32'd1);
    chk("lw_strikes", 32'(bif.strikes), 32'd1);

`ifdef BOMB_CTRL_PENALTY_EN
    go_idle();
    cycle(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, "pen_arm");
    enter_code(4'd1, 4'd2, 4'd3, 4'd5);
    chk("pen_sec2", 32'(bif.sec), 32'd2);
    chk("pen_str1", 32'(bif.strikes), 32'd1);
    enter_code(4'd1, 4'd2, 4'd3, 4'd5);
    chk("pen_sec0", 32'(bif.sec), 32'd0);
    chk("pen_bomb", 32'(bif.bomb), 32'd1);
`else
    go_idle();
    cycle(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, "nopen_arm");
    enter_code(4'd1, 4'd2, 4'd3, 4'd5);
    chk("nopen_sec", 32'(bif.sec), 32'd12);
`endif

    // random play, with an asynchronous reset in the middle of a game
    mb = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        go_idle();
        cycle(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, "mid_arm");
        cycle(1'b1, 1'b0, 1'b1, 4'd1, 1'b1, "mid_play");
        @(negedge clk);
        bif.tick = 1'b0; bif.arm = 1'b0; bif.key_valid = 1'b0; bif.mute_btn = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        @(posedge clk);
        #1;
        compare_all("rst_held");
        @(negedge clk);
        rst = 1'b1;
        mb = 1'b0;
      end
      t  = ($urandom_range(0, 3) == 0);
      a  = ($urandom_range(0, 24) == 0);
      kv = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 3) != 0) k = 4'(cd[mq.size() % 4]);
      else k = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) mb = ~mb;
      cycle(t, a, kv, k, mb, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
